// File: rtl/hvac_actuator_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// home_auto_pkg
// Shared encodings for the home-automation HVAC blocks. The state encoding is
// visible on hvac_actuator_ctrl.state_o and is decoded by status/display
// logic, so the numeric values are fixed.
//   hvac_state_t : IDLE=0, PRE=1, HEAT=2, COOL=3, POST=4
//   hvac_mode_t  : which actuator a start sequence is heading for
//   hvac_max4    : constant helper used to size the shared timers
// ----------------------------------------------------------------------------
package home_auto_pkg;

    localparam int HVAC_STATE_W = 3;

    typedef enum logic [HVAC_STATE_W-1:0] {
        HVAC_IDLE = 3'd0,
        HVAC_PRE  = 3'd1,
        HVAC_HEAT = 3'd2,
        HVAC_COOL = 3'd3,
        HVAC_POST = 3'd4
    } hvac_state_t;

    typedef enum logic {
        MODE_HEAT = 1'b0,
        MODE_COOL = 1'b1
    } hvac_mode_t;

    function automatic int hvac_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/hvac_actuator_ctrl_dwell_timer.sv
// ----------------------------------------------------------------------------
// dwell_timer
// Loadable down-counter advanced by the shared timing tick. A load wins over
// a tick on the same edge; the count saturates at zero.
//   clk      : system clock
//   reset    : asynchronous, active-low
//   load     : load load_val on this edge
//   load_val : value to load
//   tick     : decrement enable (one cycle per timing tick)
//   count    : current count (registered)
//   zero     : count == 0 (registered alongside count)
// ----------------------------------------------------------------------------
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_reg, count_next;
    logic         zero_reg;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (tick && (count_reg != '0)) begin
            count_next = count_reg - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            zero_reg  <= 1'b1;
        end else begin
            count_reg <= count_next;
            zero_reg  <= (count_next == '0);
        end
    end

    assign count = count_reg;
    assign zero  = zero_reg;

endmodule

// File: rtl/hvac_actuator_ctrl.sv
// ----------------------------------------------------------------------------
// hvac_actuator_ctrl
// Turns thermostat heat/cool requests into safe heater, compressor and fan
// drive: fan pre-run, minimum on-time, fan post-run, short-cycle lockout and
// heat/cool mutual exclusion. All outputs are registered.
//   clk           : system clock
//   reset         : asynchronous, active-low
//   heat_req      : heating request
//   cool_req      : cooling request
//   heater_en     : heater relay drive
//   compressor_en : compressor relay drive
//   fan_en        : blower drive
//   lockout       : restart lockout counter is non-zero
//   conflict      : heat_req and cool_req both high (one cycle late)
//   state_o       : current FSM state (home_auto_pkg::hvac_state_t)
// ----------------------------------------------------------------------------
module hvac_actuator_ctrl
    import home_auto_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int FAN_PRE  = 5,
    parameter int MIN_ON   = 60,
    parameter int MIN_OFF  = 120,
    parameter int FAN_POST = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    heat_req,
    input  logic                    cool_req,
    output logic                    heater_en,
    output logic                    compressor_en,
    output logic                    fan_en,
    output logic                    lockout,
    output logic                    conflict,
    output logic [HVAC_STATE_W-1:0] state_o
);

    localparam int TW = $clog2(hvac_max4(FAN_PRE, MIN_ON, MIN_OFF, FAN_POST) + 1);
    localparam int PW = $clog2(TICK_DIV) + 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE   = PW'(1);
    localparam logic [TW-1:0] T_FAN_PRE   = TW'(FAN_PRE);
    localparam logic [TW-1:0] T_MIN_ON    = TW'(MIN_ON);
    localparam logic [TW-1:0] T_MIN_OFF   = TW'(MIN_OFF);
    localparam logic [TW-1:0] T_FAN_POST  = TW'(FAN_POST);

    // ---------------- prescaler ----------------
    logic [PW-1:0] presc_reg;
    logic          tick;

    assign tick = (presc_reg == PRESC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) presc_reg <= '0;
        else        presc_reg <= tick ? '0 : presc_reg + PRESC_ONE;
    end

    // ---------------- effective requests ----------------
    // Simultaneous heat and cool requests cancel each other out.
    logic h_eff, c_eff, req_held;

    assign h_eff = heat_req & ~cool_req;
    assign c_eff = cool_req & ~heat_req;

    // ---------------- FSM state ----------------
    hvac_state_t state_reg, state_next;
    hvac_mode_t  mode_reg, mode_next;

    // The latched request disappears when it drops or when the opposite
    // request appears (which also makes it a conflict).
    assign req_held = (mode_reg == MODE_HEAT) ? h_eff : c_eff;

    // ---------------- timers ----------------
    logic          dwell_load, lock_load;
    logic [TW-1:0] dwell_val;
    logic [TW-1:0] dwell_count, lock_count;
    logic          dwell_zero, lock_zero;
    logic          dwell_done;

    dwell_timer #(.W(TW)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     (dwell_load),
        .load_val (dwell_val),
        .tick     (tick),
        .count    (dwell_count),
        .zero     (dwell_zero)
    );

    dwell_timer #(.W(TW)) u_lock (
        .clk      (clk),
        .reset    (reset),
        .load     (lock_load),
        .load_val (T_MIN_OFF),
        .tick     (tick),
        .count    (lock_count),
        .zero     (lock_zero)
    );

    // The flag and the count agree by construction; the count test folds away.
    assign dwell_done = dwell_zero & (dwell_count == '0);

    // Every state change reloads the dwell timer with the new state's dwell.
    assign dwell_load = (state_next != state_reg);
    assign lock_load  = (state_next == HVAC_POST) && (state_reg != HVAC_POST);

    always_comb begin
        dwell_val = '0;
        case (state_next)
            HVAC_PRE:             dwell_val = T_FAN_PRE;
            HVAC_HEAT, HVAC_COOL: dwell_val = T_MIN_ON;
            HVAC_POST:            dwell_val = T_FAN_POST;
            default:              dwell_val = '0;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= HVAC_IDLE;
            mode_reg  <= MODE_HEAT;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        case (state_reg)
            HVAC_IDLE: begin
                if ((h_eff | c_eff) && lock_zero) begin
                    state_next = HVAC_PRE;
                    mode_next  = c_eff ? MODE_COOL : MODE_HEAT;
                end
            end
            HVAC_PRE: begin
                // Nothing has been energised yet, so an abort needs no lockout.
                if (!req_held) begin
                    state_next = HVAC_IDLE;
                end else if (dwell_done) begin
                    state_next = (mode_reg == MODE_HEAT) ? HVAC_HEAT : HVAC_COOL;
                end
            end
            HVAC_HEAT, HVAC_COOL: begin
                if (dwell_done && !req_held) state_next = HVAC_POST;
            end
            HVAC_POST: begin
                if (dwell_done) state_next = HVAC_IDLE;
            end
            default: state_next = HVAC_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as state_o.
    logic heater_next, compressor_next, fan_next;
    logic heater_en_reg, compressor_en_reg, fan_en_reg, conflict_reg;

    always_comb begin
        heater_next     = (state_next == HVAC_HEAT);
        compressor_next = (state_next == HVAC_COOL);
        fan_next        = (state_next != HVAC_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            heater_en_reg     <= 1'b0;
            compressor_en_reg <= 1'b0;
            fan_en_reg        <= 1'b0;
            conflict_reg      <= 1'b0;
        end else begin
            heater_en_reg     <= heater_next;
            compressor_en_reg <= compressor_next;
            fan_en_reg        <= fan_next;
            conflict_reg      <= heat_req & cool_req;
        end
    end

    assign heater_en     = heater_en_reg;
    assign compressor_en = compressor_en_reg;
    assign fan_en        = fan_en_reg;
    assign conflict      = conflict_reg;
    assign lockout       = (lock_count != '0);
    assign state_o       = state_reg;

endmodule

// File: tb/tb_hvac_actuator_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hvac_actuator_ctrl
// Directed scenarios followed by random request patterns. Expected outputs
// come from a cycle-level reference model that tracks how long the
// controller has been in each phase and how long ago the last actuator
// release happened.
// ----------------------------------------------------------------------------
module tb_hvac_actuator_ctrl;

    localparam int TICK_DIV = 1;
    localparam int FAN_PRE  = 2;
    localparam int MIN_ON   = 4;
    localparam int MIN_OFF  = 6;
    localparam int FAN_POST = 3;

    // State numbering as visible on state_o.
    localparam int S_IDLE = 0;
    localparam int S_PRE  = 1;
    localparam int S_HEAT = 2;
    localparam int S_COOL = 3;
    localparam int S_POST = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       heat_req = 1'b0;
    logic       cool_req = 1'b0;
    logic       heater_en, compressor_en, fan_en, lockout, conflict;
    logic [2:0] state_o;

    hvac_actuator_ctrl #(
        .TICK_DIV (TICK_DIV),
        .FAN_PRE  (FAN_PRE),
        .MIN_ON   (MIN_ON),
        .MIN_OFF  (MIN_OFF),
        .FAN_POST (FAN_POST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .heat_req      (heat_req),
        .cool_req      (cool_req),
        .heater_en     (heater_en),
        .compressor_en (compressor_en),
        .fan_en        (fan_en),
        .lockout       (lockout),
        .conflict      (conflict),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // ---------------- reference model ----------------
    int m_st;          // current phase
    int m_age;         // cycles already spent in the phase (0 on entry)
    int m_since;       // cycles since the last actuator release, saturating at MIN_OFF
    bit m_heat_mode;   // start sequence heading for heat
    bit m_conf;        // both requests seen on the previous edge

    task automatic model_reset();
        m_st        = S_IDLE;
        m_age       = 0;
        m_since     = MIN_OFF;
        m_heat_mode = 1'b1;
        m_conf      = 1'b0;
    endtask

    task automatic model_edge();
        bit h, c, want;
        int nxt;
        h    = heat_req && !cool_req;
        c    = cool_req && !heat_req;
        want = m_heat_mode ? h : c;
        nxt  = m_st;
        case (m_st)
            S_IDLE: if ((h || c) && (m_since >= MIN_OFF)) begin
                nxt = S_PRE;
                m_heat_mode = h;
            end
            S_PRE: begin
                if (!want)                nxt = S_IDLE;
                else if (m_age >= FAN_PRE) nxt = m_heat_mode ? S_HEAT : S_COOL;
            end
            S_HEAT, S_COOL: if ((m_age >= MIN_ON) && !want) nxt = S_POST;
            S_POST: if (m_age >= FAN_POST) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if ((nxt == S_POST) && (m_st != S_POST)) m_since = 0;
        else if (m_since < MIN_OFF)              m_since = m_since + 1;
        m_age  = (nxt != m_st) ? 0 : m_age + 1;
        m_st   = nxt;
        m_conf = heat_req && cool_req;
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk3("state_o", state_o, 3'(m_st));
        chk1("heater_en", heater_en, m_st == S_HEAT);
        chk1("compressor_en", compressor_en, m_st == S_COOL);
        chk1("fan_en", fan_en, m_st != S_IDLE);
        chk1("lockout", lockout, m_since < MIN_OFF);
        chk1("conflict", conflict, m_conf);
        chk1("exclusive", heater_en & compressor_en, 1'b0);
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later.
    task automatic step(input logic h, input logic c);
        heat_req = h;
        cool_req = c;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_all();
    endtask

    // Expected phase for the heat-then-cool scenario, by cycle number.
    function automatic int hc_state(input int n);
        if (n <= 3)  return S_PRE;
        if (n <= 8)  return S_HEAT;
        if (n <= 12) return S_POST;
        if (n <= 15) return S_IDLE;
        if (n <= 18) return S_PRE;
        return S_COOL;
    endfunction

    initial begin
        model_reset();

        // Reset held, then released between edges with no requests.
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all();
        end
        #3 reset = 1'b1;
        repeat (12) step(1'b0, 1'b0);

        // Heat for cycles 0..4, then cool from cycle 13 onward.
        cyc = 0;
        for (int k = 0; k < 25; k++) begin
            step(k < 5, k >= 13);
            chk3("hc_state", state_o, 3'(hc_state(k + 1)));
            chk1("hc_lockout", lockout, (k + 1 >= 9) && (k + 1 <= 14));
        end
        repeat (16) step(1'b0, 1'b0);

        // Both requests in IDLE: conflict only, nothing starts.
        repeat (5) step(1'b1, 1'b1);
        chk1("conflict_on", conflict, 1'b1);
        chk1("conflict_fan", fan_en, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Cool request raised during HEAT: heater held for its minimum on-time.
        repeat (5) step(1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b1);
        repeat (16) step(1'b0, 1'b0);

        // One-cycle heat pulse: PRE then straight back to IDLE.
        step(1'b1, 1'b0);
        chk3("pulse_pre", state_o, 3'(S_PRE));
        repeat (5) step(1'b0, 1'b0);

        // Asynchronous reset in the middle of HEAT.
        repeat (6) step(1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk1("async_heater", heater_en, 1'b0);
        chk1("async_fan", fan_en, 1'b0);
        chk3("async_state", state_o, 3'(S_IDLE));
        heat_req = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all();
        end
        #3 reset = 1'b1;
        repeat (4) step(1'b0, 1'b0);

        // Random request patterns with random hold lengths.
        for (int s = 0; s < 40; s++) begin
            int pat;
            int len;
            pat = int'($urandom_range(0, 3));
            len = int'($urandom_range(1, 15));
            for (int i = 0; i < len; i++) step(pat[0], pat[1]);
        end
        repeat (20) step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
